// File: rtl/module_fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID register.
// Fetches over req/gnt/rvalid and buffers responses in a small in-order FIFO.
module module_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_d_i,
   input  logic        flush_d_i,
   input  logic        pc_src_e_i,
   input  logic [31:0] pc_target_e_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc_plus4_d_o,
   output logic        valid_d_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = CW + 1;
   localparam logic [DW-1:0] DEPTH_W = DW'(FIFO_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   pc_f;
   logic [31:0]   rsp_pc;
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic [31:0]   fifo_pc [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] fifo_cnt;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard_cnt;
   logic [DW-1:0] in_use;
   logic [31:0]   redirect_pc;
   logic          grant;
   logic          rsp;
   logic          drop;
   logic          accept;
   logic          fifo_empty;
   logic          load_ok;
   logic          pop;
   logic          bypass;
   logic          push;
   logic          unused;

   assign unused      = ^pc_target_e_i[1:0];
   assign redirect_pc = {pc_target_e_i[31:2], 2'b00};

   // Buffered plus in-flight words never exceed the FIFO capacity
   assign in_use      = {1'b0, fifo_cnt} + {1'b0, outstanding};
   assign imem_req_o  = rst_n_i && !pc_src_e_i && (in_use < DEPTH_W);
   assign imem_addr_o = pc_f;
   assign grant       = imem_req_o && imem_gnt_i;

   assign rsp        = imem_rvalid_i && (outstanding != '0);
   assign drop       = rsp && (discard_cnt != '0);
   assign accept     = rsp && !drop;
   assign fifo_empty = (fifo_cnt == '0);
   assign load_ok    = !flush_d_i && !pc_src_e_i && !stall_d_i;
   assign pop        = load_ok && !fifo_empty;
   assign bypass     = load_ok && fifo_empty && accept;
   assign push       = accept && !bypass && !pc_src_e_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pc_f        <= RESET_PC;
         rsp_pc      <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_cnt    <= '0;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(rsp);
         if (pc_src_e_i) begin
            pc_f        <= redirect_pc;
            rsp_pc      <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            discard_cnt <= outstanding - CW'(rsp);
         end else begin
            if (grant)  pc_f        <= pc_f + 32'd4;
            if (accept) rsp_pc      <= rsp_pc + 32'd4;
            if (drop)   discard_cnt <= discard_cnt - CW'(1);
            if (push)   wr_ptr      <= wr_ptr + AW'(1);
            if (pop)    rd_ptr      <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata_i;
         fifo_pc[wr_ptr]    <= rsp_pc;
      end
   end

   // Flush outranks stall; the FIFO head outranks the bypass path
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         instr_d_o    <= NOP;
         pc_d_o       <= 32'd0;
         pc_plus4_d_o <= 32'd4;
         valid_d_o    <= 1'b0;
      end else if (flush_d_i || pc_src_e_i) begin
         instr_d_o <= NOP;
         valid_d_o <= 1'b0;
      end else if (stall_d_i) begin
         valid_d_o <= valid_d_o;
      end else if (!fifo_empty) begin
         instr_d_o    <= fifo_instr[rd_ptr];
         pc_d_o       <= fifo_pc[rd_ptr];
         pc_plus4_d_o <= fifo_pc[rd_ptr] + 32'd4;
         valid_d_o    <= 1'b1;
      end else if (accept) begin
         instr_d_o    <= imem_rdata_i;
         pc_d_o       <= rsp_pc;
         pc_plus4_d_o <= rsp_pc + 32'd4;
         valid_d_o    <= 1'b1;
      end else begin
         instr_d_o <= NOP;
         valid_d_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_module_fetch_stage.sv
// Bench for module_fetch_stage: directed scenarios then random traffic,
// checked against a transaction-level model of the fetch stream.
module tb_module_fetch_stage;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        stall_d_i;
   logic        flush_d_i;
   logic        pc_src_e_i;
   logic [31:0] pc_target_e_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_d_o;
   logic [31:0] pc_d_o;
   logic [31:0] pc_plus4_d_o;
   logic        valid_d_o;

   always #5 clk = ~clk;

   module_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n_i),
      .stall_d_i     (stall_d_i),
      .flush_d_i     (flush_d_i),
      .pc_src_e_i    (pc_src_e_i),
      .pc_target_e_i (pc_target_e_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_d_o     (instr_d_o),
      .pc_d_o        (pc_d_o),
      .pc_plus4_d_o  (pc_plus4_d_o),
      .valid_d_o     (valid_d_o)
   );

   // Memory: addresses granted but not yet returned, in order
   logic [31:0] mq[$];
   int nchk = 0;
   int nerr = 0;
   // Model: words available to decode, words to drop, ignored late words
   int avail = 0;
   int stale = 0;
   int ghost = 0;
   logic [31:0] fexp, spc;
   logic        e_v;
   logic [31:0] e_i, e_p, e_p4;
   logic        gnt_en, rv_en;
   int          nval;
   bit          found;

   function automatic logic [31:0] tag(input logic [31:0] a);
      return a ^ 32'hC0DE_0003;
   endfunction

   task automatic chk(input string nm, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", nm, obs, exp);
      end
   endtask

   task automatic cycle();
      logic g, rv, st, fl, ps, rs;
      logic [31:0] a, tg;
      imem_gnt_i    = gnt_en;
      imem_rvalid_i = (mq.size() > 0) && (rv_en || ghost > 0 || !rst_n_i);
      imem_rdata_i  = imem_rvalid_i ? tag(mq[0]) : $urandom;
      #1;
      chk("req", imem_req_o, rst_n_i && !pc_src_e_i &&
          (avail + int'(mq.size()) - ghost < DEPTH));
      if (rst_n_i) chk("addr", imem_addr_o, fexp);
      @(posedge clk);
      g  = imem_req_o && imem_gnt_i;
      a  = imem_addr_o;
      rv = imem_rvalid_i;
      st = stall_d_i;
      fl = flush_d_i;
      ps = pc_src_e_i;
      rs = rst_n_i;
      tg = pc_target_e_i;
      #1;
      if (rv) begin
         void'(mq.pop_front());
         if (ghost > 0) ghost--;
         else if (rs && stale > 0) stale--;
         else if (rs && !ps) avail++;
      end
      if (g) begin
         mq.push_back(a);
         fexp = fexp + 32'd4;
      end
      if (!rs) begin
         ghost = mq.size();
         stale = 0;
         avail = 0;
         fexp  = RPC;
         spc   = RPC;
         e_v = 1'b0; e_i = NOP; e_p = 32'd0; e_p4 = 32'd4;
      end else if (ps) begin
         stale = mq.size() - ghost;
         avail = 0;
         fexp  = {tg[31:2], 2'b00};
         spc   = fexp;
         e_v = 1'b0; e_i = NOP;
      end else if (fl) begin
         e_v = 1'b0; e_i = NOP;
      end else if (!st) begin
         if (avail > 0) begin
            avail--;
            e_v = 1'b1; e_i = tag(spc); e_p = spc; e_p4 = spc + 32'd4;
            spc = spc + 32'd4;
         end else begin
            e_v = 1'b0; e_i = NOP;
         end
      end
      chk("valid", valid_d_o, e_v);
      chk("instr", instr_d_o, e_i);
      if (e_v || !rs) begin
         chk("pc", pc_d_o, e_p);
         chk("pc4", pc_plus4_d_o, e_p4);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
      pc_src_e_i = 1'b0; pc_target_e_i = 32'd0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
      gnt_en = 1'b1; rv_en = 1'b1;
      fexp = RPC; spc = RPC;
      e_v = 1'b0; e_i = NOP; e_p = 32'd0; e_p4 = 32'd4;
      @(negedge clk);
      repeat (2) cycle();
      chk("rst_valid", valid_d_o, 1'b0);
      chk("rst_pc4", pc_plus4_d_o, 32'd4);
      rst_n_i = 1'b1;

      // Ideal memory: first word two edges after the first grant
      cycle();
      chk("lat0", valid_d_o, 1'b0);
      cycle();
      chk("lat1", valid_d_o, 1'b1);
      chk("first_pc", pc_d_o, RPC);
      cycle();
      cycle();
      chk("pc8", pc_d_o, 32'd8);

      // Stall holds decode while the FIFO fills
      stall_d_i = 1'b1;
      repeat (3) begin
         cycle();
         chk("stall_hold", pc_d_o, 32'd8);
      end
      chk("stall_noreq", imem_req_o, 1'b0);
      stall_d_i = 1'b0;
      cycle();
      chk("after_stall12", pc_d_o, 32'd12);
      cycle();
      chk("after_stall16", pc_d_o, 32'd16);
      chk("after_stall_v", valid_d_o, 1'b1);

      // Grant withheld
      gnt_en = 1'b0;
      repeat (4) cycle();
      chk("gnt_bubble", valid_d_o, 1'b0);
      gnt_en = 1'b1;
      repeat (4) cycle();
      nval = 0;
      repeat (8) begin
         cycle();
         nval += int'(valid_d_o);
      end
      chk("tput", nval, 8);

      // Redirect with requests in flight
      rv_en = 1'b0;
      repeat (2) cycle();
      chk("two_out", mq.size(), 2);
      pc_src_e_i = 1'b1; pc_target_e_i = 32'h0000_0102;
      cycle();
      pc_src_e_i = 1'b0; rv_en = 1'b1;
      chk("redir_addr", imem_addr_o, 32'h0000_0100);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (valid_d_o) begin
            found = 1'b1;
            chk("redir_pc", pc_d_o, 32'h0000_0100);
            chk("redir_pc4", pc_plus4_d_o, 32'h0000_0104);
         end
      end
      chk("redir_seen", found, 1'b1);

      // Flush together with stall
      repeat (3) cycle();
      stall_d_i = 1'b1;
      repeat (2) cycle();
      flush_d_i = 1'b1;
      cycle();
      chk("fl_instr", instr_d_o, NOP);
      chk("fl_valid", valid_d_o, 1'b0);
      flush_d_i = 1'b0; stall_d_i = 1'b0;
      cycle();
      chk("fl_head", valid_d_o, 1'b1);

      // Reset with a request in flight and buffered words
      stall_d_i = 1'b1;
      cycle();
      rv_en = 1'b0;
      repeat (2) cycle();
      rst_n_i = 1'b0;
      cycle();
      rst_n_i = 1'b1; stall_d_i = 1'b0; rv_en = 1'b1;
      chk("rst_addr", imem_addr_o, RPC);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (valid_d_o) begin
            found = 1'b1;
            chk("rst_first_pc", pc_d_o, RPC);
         end
      end
      chk("rst_seen", found, 1'b1);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         gnt_en        = ($urandom_range(3) != 0);
         rv_en         = ($urandom_range(9) < 7);
         stall_d_i     = ($urandom_range(6) == 0);
         flush_d_i     = ($urandom_range(19) == 0);
         pc_src_e_i    = ($urandom_range(24) == 0);
         pc_target_e_i = $urandom;
         rst_n_i       = ($urandom_range(99) != 0);
         cycle();
      end
      rst_n_i = 1'b1; stall_d_i = 1'b0; flush_d_i = 1'b0;
      pc_src_e_i = 1'b0; gnt_en = 1'b1; rv_en = 1'b1;
      repeat (6) cycle();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
